// File: rtl/line_in_control.sv
// line_in_control: I2S master receiver for the codec ADC (line-in) path.
// Derives MCLK/SCK/LRCK from a free-running 9-bit frame counter.
// Deserializes SDOUT MSB-first into 16-bit left/right samples with no I2S
// one-bit delay, and publishes each completed stereo pair with a one-cycle
// valid strobe.
//
// Output strobe semantics: sample_valid is a one-cycle pulse with no ready.
// audio_left/audio_right change only on the edge that raises sample_valid.
// They hold their value until the next pulse, so downstream logic may sample
// them on the pulse or at any later point in the same frame.
module line_in_control #(
   parameter logic [3:0] SAMPLE_PHASE = 4'd11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        audio_sdout,
   output logic        audio_mclk,
   output logic        audio_sck,
   output logic        audio_lrck,
   output logic [15:0] audio_left,
   output logic [15:0] audio_right,
   output logic        sample_valid
);

   // Counter value at which the last right-channel bit is captured.
   localparam logic [8:0] DONE_CNT = {1'b1, 4'hF, SAMPLE_PHASE};

   logic [8:0]  cnt;
   logic        sd_s1;
   logic        sd_s2;
   logic [15:0] shift_l;
   logic [15:0] shift_r;
   logic        strobe;
   logic        frame_done;

   // Sample SDOUT once per SCK period, inside the SCK-high half.
   assign strobe     = (cnt[3:0] == SAMPLE_PHASE);
   assign frame_done = (cnt == DONE_CNT);

   // Clock outputs come straight from counter flops, so they are glitch-free.
   assign audio_lrck = cnt[8];
   assign audio_sck  = cnt[3];
   assign audio_mclk = cnt[1];

   // Free-running frame counter; wraps naturally at 0x1FF.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 9'd0;
      end else begin
         cnt <= cnt + 9'd1;
      end
   end

   // Two-flop synchronizer for the asynchronous codec data line.
   always_ff @(posedge clk) begin
      if (rst) begin
         sd_s1 <= 1'b0;
         sd_s2 <= 1'b0;
      end else begin
         sd_s1 <= audio_sdout;
         sd_s2 <= sd_s1;
      end
   end

   // Shift the synchronized bit into the channel selected by cnt[8], MSB first.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_l <= 16'd0;
         shift_r <= 16'd0;
      end else if (strobe) begin
         if (cnt[8]) begin
            shift_r <= {shift_r[14:0], sd_s2};
         end else begin
            shift_l <= {shift_l[14:0], sd_s2};
         end
      end
   end

   // Publish the stereo pair; the last right bit is merged in directly since
   // shift_r only absorbs it on this same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         audio_left   <= 16'd0;
         audio_right  <= 16'd0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= frame_done;
         if (frame_done) begin
            audio_left  <= shift_l;
            audio_right <= {shift_r[14:0], sd_s2};
         end
      end
   end

endmodule

// File: tb/tb_line_in_control.sv
// tb_line_in_control: drives a codec model onto three receiver instances
// (SAMPLE_PHASE 11, 8, 15) and compares every output on every cycle against
// a frame-level model computed from the cycle count since reset release.
module tb_line_in_control;

   localparam int NI = 3;
   localparam logic [3:0] SP [NI] = '{4'd11, 4'd8, 4'd15};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic audio_sdout = 1'b0;

   logic        mclk_w  [NI];
   logic        sck_w   [NI];
   logic        lrck_w  [NI];
   logic [15:0] left_w  [NI];
   logic [15:0] right_w [NI];
   logic        valid_w [NI];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [15:0] fl [32];
   logic [15:0] fr [32];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   line_in_control #(.SAMPLE_PHASE(SP[0])) u_dut0 (
      .clk(clk), .rst(rst), .audio_sdout(audio_sdout),
      .audio_mclk(mclk_w[0]), .audio_sck(sck_w[0]), .audio_lrck(lrck_w[0]),
      .audio_left(left_w[0]), .audio_right(right_w[0]), .sample_valid(valid_w[0]));
   line_in_control #(.SAMPLE_PHASE(SP[1])) u_dut1 (
      .clk(clk), .rst(rst), .audio_sdout(audio_sdout),
      .audio_mclk(mclk_w[1]), .audio_sck(sck_w[1]), .audio_lrck(lrck_w[1]),
      .audio_left(left_w[1]), .audio_right(right_w[1]), .sample_valid(valid_w[1]));
   line_in_control #(.SAMPLE_PHASE(SP[2])) u_dut2 (
      .clk(clk), .rst(rst), .audio_sdout(audio_sdout),
      .audio_mclk(mclk_w[2]), .audio_sck(sck_w[2]), .audio_lrck(lrck_w[2]),
      .audio_left(left_w[2]), .audio_right(right_w[2]), .sample_valid(valid_w[2]));

   // ---------------- checker ----------------
   task automatic chk(input string name, input int i, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 25)
            $display("FAIL %s inst%0d cyc=%0d: got %h expected %h",
                     name, i, cyc, act, exp);
      end
   endtask

   // Codec model: bit for a given cycle since reset release. Within each
   // 512-cycle frame, the first 256 cycles carry left, the rest right; each
   // bit lasts 16 cycles, MSB first.
   function automatic logic pin_bit(input int c);
      int p;
      int f;
      int b;
      p = c % 512;
      f = (c / 512) % 32;
      b = 15 - ((p % 256) / 16);
      if (p >= 256) return fr[f][b];
      return fl[f][b];
   endfunction

   // Driver: track cycles since release; change data just after each edge,
   // which lands on SCK falling edges (bit boundaries every 16 cycles).
   initial begin
      forever begin
         @(posedge clk);
         if (rst) cyc = 0;
         else cyc = cyc + 1;
         #1 audio_sdout = pin_bit(cyc);
      end
   end

   // Per-cycle comparison of every output against the frame-level model.
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         int done;
         int k;
         logic ev;
         logic [15:0] el;
         logic [15:0] er;
         done = 32'h1F1 + int'(SP[i]);
         ev = (cyc >= done) && (((cyc - done) % 512) == 0);
         k  = (cyc >= done) ? ((cyc - done) / 512) : -1;
         el = (k < 0) ? 16'h0000 : fl[k % 32];
         er = (k < 0) ? 16'h0000 : fr[k % 32];
         chk("mclk",  i, {15'd0, mclk_w[i]},  {15'd0, ((cyc % 4) >= 2)});
         chk("sck",   i, {15'd0, sck_w[i]},   {15'd0, ((cyc % 16) >= 8)});
         chk("lrck",  i, {15'd0, lrck_w[i]},  {15'd0, ((cyc % 512) >= 256)});
         chk("valid", i, {15'd0, valid_w[i]}, {15'd0, ev});
         chk("left",  i, left_w[i],  el);
         chk("right", i, right_w[i], er);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int w;
      fl[0] = 16'hA5C3; fr[0] = 16'h0F0F;
      fl[1] = 16'h8000; fr[1] = 16'h7FFF;
      fl[2] = 16'hFFFF; fr[2] = 16'h0000;
      fl[3] = 16'h0000; fr[3] = 16'hFFFF;
      for (int f = 4; f < 32; f++) begin
         fl[f] = 16'($urandom_range(0, 65535));
         fr[f] = 16'($urandom_range(0, 65535));
      end
      audio_sdout = pin_bit(0);
      rst = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      // Reset state, pinned literally.
      chk("rst_mclk",  0, {15'd0, mclk_w[0]},  16'h0000);
      chk("rst_sck",   0, {15'd0, sck_w[0]},   16'h0000);
      chk("rst_lrck",  0, {15'd0, lrck_w[0]},  16'h0000);
      chk("rst_valid", 0, {15'd0, valid_w[0]}, 16'h0000);
      chk("rst_left",  0, left_w[0],  16'h0000);
      chk("rst_right", 0, right_w[0], 16'h0000);
      rst = 1'b0;

      // First pulse 508 edges after release, with the fixed pattern.
      repeat (508) @(posedge clk);
      @(negedge clk);
      chk("first_valid", 0, {15'd0, valid_w[0]}, 16'h0001);
      chk("first_left",  0, left_w[0],  16'hA5C3);
      chk("first_right", 0, right_w[0], 16'h0F0F);
      repeat (512) @(posedge clk);
      @(negedge clk);
      chk("ext_valid", 0, {15'd0, valid_w[0]}, 16'h0001);
      chk("ext_left",  0, left_w[0],  16'h8000);
      chk("ext_right", 0, right_w[0], 16'h7FFF);

      // Run several more frames of random data.
      repeat (512 * 6) @(posedge clk);

      // Mid-frame reset at cnt 0x0A0 for three cycles.
      w = 0;
      @(posedge clk); #1;
      while (((cyc % 512) != 32'hA0) && (w < 1000)) begin
         @(posedge clk); #1;
         w++;
      end
      checks++;
      if (w >= 1000) begin
         failures++;
         $display("FAIL wait_cnt_a0: got timeout expected cnt 0x0A0");
      end
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("mid_rst_valid", 0, {15'd0, valid_w[0]}, 16'h0000);
         chk("mid_rst_left",  0, left_w[0],  16'h0000);
         chk("mid_rst_sck",   0, {15'd0, sck_w[0]}, 16'h0000);
      end
      rst = 1'b0;
      repeat (508) @(posedge clk);
      @(negedge clk);
      chk("post_rst_valid", 0, {15'd0, valid_w[0]}, 16'h0001);
      chk("post_rst_left",  0, left_w[0],  16'hA5C3);
      chk("post_rst_right", 0, right_w[0], 16'h0F0F);

      repeat (512 * 4) @(posedge clk);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
